cmp_result_tally: RTL and testbench
===================================

# cmp_result_tally

Windowed result collector placed directly downstream of `comparator_4bit`. Each valid cycle it accepts the operand pair `A`/`B` with the comparator's `AlB`/`AgB`/`AeB` flags. Over a window of `WIN` accepted samples it counts less-than, greater-than and equal outcomes and tracks the largest absolute difference |A−B|. It then reports a one-cycle `done` and holds the results until the next `start`.

## Interface
- `CNT_W`, 8: width of each outcome counter; counters saturate at 2^CNT_W−1.
- `WIN`, 16: accepted samples per window; legal range 1..255.

- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  begins a window; honoured only in IDLE.
- `in_valid`  input  1  sample qualifier; sample accepted only when `in_valid`=1 in RUN.
- `A`  input  4  comparator operand A.
- `B`  input  4  comparator operand B.
- `AlB`, `AgB`, `AeB`  input  1 each  comparator flags for the same cycle's `A`/`B`.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse when the window completes.
- `lt_cnt`, `gt_cnt`, `eq_cnt`  output  CNT_W each  outcome counts for the current or last window.
- `max_diff`  output  4  max |A−B| over accepted samples.
- `err`  output  1  sticky flag-consistency error; see Configuration.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start`=1 → RUN. On entry, all counters, `max_diff`, `err` and the internal sample count are cleared.
  - RUN: each accepted sample increments the internal sample count (width ≥ 8 bits). When the count reaches WIN, the state moves to DONE.
  - DONE: lasts one cycle with `done`=1, then → IDLE unconditionally.
- Counting on acceptance:
  - `AeB` → `eq_cnt`+1; `AgB` → `gt_cnt`+1; `AlB` → `lt_cnt`+1.
  - Counters saturate and never wrap.
- Difference on acceptance:
  - `AgB` → A−B; `AlB` → B−A; `AeB` → 0.
  - `max_diff` ← max(`max_diff`, diff), 4-bit unsigned.
- `start` in RUN or DONE is ignored. `in_valid` in IDLE or DONE is ignored.
- Results hold in IDLE after DONE until the next `start`.
- Reset value of every output is 0, and the FSM resets to IDLE.
- Reset mid-window discards the partial results, and no `done` is produced.

## Timing
- One-cycle registered latency: a sample accepted at edge N is reflected in the outputs after edge N.
- `busy` rises the cycle after `start` is sampled in IDLE. A sample presented in that same `start` cycle is not accepted.
- The WIN-th accepted sample at edge N moves the FSM to DONE: `done`=1 and `busy`=0 for cycle N+1, with final counters already valid.
- A new `start` is accepted no earlier than the cycle after DONE, i.e. when back in IDLE.
- Invariant at `done` (with checking enabled and no error): `lt_cnt`+`gt_cnt`+`eq_cnt` = WIN, provided WIN ≤ 2^CNT_W−1.

## Configuration
- Macro `CMP_TALLY_ERRCHK_EN`.
- Defined: each accepted sample is checked for two conditions:
  - flags exactly one-hot;
  - flags consistent with `A`/`B` (A<B, A>B or A==B respectively).
  - A failing sample sets `err` (sticky until `start` or `rst`). It advances the sample count but changes neither the counters nor `max_diff`.
- Undefined: `err` is tied to 0. Flags are decoded by priority `AeB` > `AgB` > `AlB`. A zero-hot sample counts nothing but still advances the sample count. No consistency check against `A`/`B`.

## Test plan
- Reset then idle: `rst` pulse → all outputs 0; `in_valid` pulses without `start` → counters stay 0.
- WIN=5 window, samples (2,9,lt), (10,9,gt), (2,2,eq), (14,8,gt), (3,9,lt), back-to-back → `done` one cycle after the 5th sample.
  - Expected: `lt_cnt`=2, `gt_cnt`=2, `eq_cnt`=1, `max_diff`=7; results held afterwards.
- Gapped `in_valid` (alternate 0/1) with WIN=5 → same final counts; `done` one cycle after the 5th accepted sample; `start` pulsed mid-RUN has no effect.
- Saturation, CNT_W=2, WIN=6, all samples (5,5,eq) → `eq_cnt`=3, other counters 0.
- Reset mid-window after 3 of 5 samples → outputs 0, FSM IDLE, no `done`; a new `start` gives a fresh, correct window.
- With `CMP_TALLY_ERRCHK_EN` defined:
  - Sample (4,4) with `AgB`=1 → `err`=1, `gt_cnt` unchanged, window still completes after WIN samples.
  - `err` clears on the next `start`.

Source files
------------

// File: rtl/cmp_result_tally.sv
// Windowed tally of comparator outcomes (lt/gt/eq counts and max |A-B|) over WIN accepted samples.
// Optional macro CMP_TALLY_ERRCHK_EN enables per-sample flag one-hot/consistency checking and the sticky err flag.
module cmp_result_tally #(
    parameter int CNT_W = 8,
    parameter int WIN   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic             AlB,
    input  logic             AgB,
    input  logic             AeB,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [3:0]       max_diff,
    output logic             err
);

    localparam logic [1:0]       IDLE    = 2'd0;
    localparam logic [1:0]       RUN     = 2'd1;
    localparam logic [1:0]       DONE    = 2'd2;
    localparam logic [7:0]       WIN_CNT = 8'(WIN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt, input logic en);
        if (en && (cnt != CNT_MAX)) begin
            return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return cnt;
        end
    endfunction

    logic [1:0] state;
    logic [1:0] nextState;
    logic [7:0] sampleCnt;
    logic       accept;
    logic       incLt;
    logic       incGt;
    logic       incEq;
    logic [3:0] diff;

    assign accept = (state == RUN) && in_valid;

`ifdef CMP_TALLY_ERRCHK_EN
    logic flagsOk;

    // Accept the flags only when exactly one is set and it agrees with A/B.
    always_comb begin
        flagsOk = 1'b0;
        case ({AlB, AgB, AeB})
            3'b100:  flagsOk = (A < B);
            3'b010:  flagsOk = (A > B);
            3'b001:  flagsOk = (A == B);
            default: flagsOk = 1'b0;
        endcase
        incLt = AlB && flagsOk;
        incGt = AgB && flagsOk;
        incEq = AeB && flagsOk;
    end
`else
    // Priority decode AeB > AgB > AlB; a zero-hot sample counts nothing.
    always_comb begin
        incEq = AeB;
        incGt = !AeB && AgB;
        incLt = !AeB && !AgB && AlB;
    end
`endif

    // Absolute difference for whichever outcome was counted.
    always_comb begin
        diff = 4'd0;
        if (incGt) begin
            diff = A - B;
        end else if (incLt) begin
            diff = B - A;
        end else begin
            diff = 4'd0;
        end
    end

    // Window sequencing IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = RUN;
                end else begin
                    nextState = IDLE;
                end
            end
            RUN: begin
                if (accept && ((sampleCnt + 8'd1) == WIN_CNT)) begin
                    nextState = DONE;
                end else begin
                    nextState = RUN;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nextState;
            busy  <= (nextState == RUN);
            done  <= (nextState == DONE);
        end
    end

    // Counters and max difference; cleared on window start, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sampleCnt <= 8'd0;
            lt_cnt    <= '0;
            gt_cnt    <= '0;
            eq_cnt    <= '0;
            max_diff  <= 4'd0;
        end else if ((state == IDLE) && start) begin
            sampleCnt <= 8'd0;
            lt_cnt    <= '0;
            gt_cnt    <= '0;
            eq_cnt    <= '0;
            max_diff  <= 4'd0;
        end else if (accept) begin
            sampleCnt <= sampleCnt + 8'd1;
            lt_cnt    <= satInc(lt_cnt, incLt);
            gt_cnt    <= satInc(gt_cnt, incGt);
            eq_cnt    <= satInc(eq_cnt, incEq);
            if (diff > max_diff) begin
                max_diff <= diff;
            end
        end
    end

`ifdef CMP_TALLY_ERRCHK_EN
    // Sticky flag error, cleared only by reset or a new window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((state == IDLE) && start) begin
            err <= 1'b0;
        end else if (accept && !flagsOk) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_result_tally.sv
// Self-checking bench for cmp_result_tally: scoreboard of per-window results plus directed checks.
module tb_cmp_result_tally;

    localparam int WIN_T   = 5;
    localparam int SAT_W   = 2;
    localparam int SAT_WIN = 6;

    logic clk = 1'b0;
    logic rst, start, startSat, in_valid;
    logic [3:0] A, B;
    logic AlB, AgB, AeB;

    logic busy, done, err;
    logic [7:0] lt_cnt, gt_cnt, eq_cnt;
    logic [3:0] max_diff;

    logic busySat, doneSat, errSat;
    logic [SAT_W-1:0] ltSat, gtSat, eqSat;
    logic [3:0] maxSat;

    always #5 clk = ~clk;

    cmp_result_tally #(.CNT_W(8), .WIN(WIN_T)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .A(A), .B(B), .AlB(AlB), .AgB(AgB), .AeB(AeB),
        .busy(busy), .done(done), .lt_cnt(lt_cnt), .gt_cnt(gt_cnt),
        .eq_cnt(eq_cnt), .max_diff(max_diff), .err(err)
    );

    cmp_result_tally #(.CNT_W(SAT_W), .WIN(SAT_WIN)) dutSat (
        .clk(clk), .rst(rst), .start(startSat), .in_valid(in_valid),
        .A(A), .B(B), .AlB(AlB), .AgB(AgB), .AeB(AeB),
        .busy(busySat), .done(doneSat), .lt_cnt(ltSat), .gt_cnt(gtSat),
        .eq_cnt(eqSat), .max_diff(maxSat), .err(errSat)
    );

    typedef struct { int lt; int gt; int eq; int md; int er; } res_t;
    res_t expQ[$];
    res_t monR;

    int checks = 0;
    int errors = 0;
    int doneSeen = 0;
    int mLt, mGt, mEq, mMax, mErr, mCnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        mLt = 0; mGt = 0; mEq = 0; mMax = 0; mErr = 0; mCnt = 0;
    endtask

    // Reference behaviour of one accepted sample on the main instance.
    task automatic modelSample(input logic [3:0] a, input logic [3:0] b, input logic l, input logic g, input logic e);
        logic il, ig, ie, bad;
        logic [3:0] d;
        res_t r;
`ifdef CMP_TALLY_ERRCHK_EN
        bad = 1'b1;
        if ({l, g, e} == 3'b100 && a < b) bad = 1'b0;
        if ({l, g, e} == 3'b010 && a > b) bad = 1'b0;
        if ({l, g, e} == 3'b001 && a == b) bad = 1'b0;
        ie = e && !bad; ig = g && !bad; il = l && !bad;
`else
        bad = 1'b0;
        ie = e; ig = g && !e; il = l && !e && !g;
`endif
        if (bad) mErr = 1;
        d = 4'd0;
        if (ig) d = a - b;
        else if (il) d = b - a;
        if (ie && mEq < 255) mEq++;
        if (ig && mGt < 255) mGt++;
        if (il && mLt < 255) mLt++;
        if (int'(d) > mMax) mMax = int'(d);
        mCnt++;
        if (mCnt == WIN_T) begin
            r.lt = mLt; r.gt = mGt; r.eq = mEq; r.md = mMax; r.er = mErr;
            expQ.push_back(r);
        end
    endtask

    task automatic sample(input logic [3:0] a, input logic [3:0] b, input logic [2:0] lge, input bit doModel);
        A = a; B = b; {AlB, AgB, AeB} = lge; in_valid = 1'b1;
        if (doModel) modelSample(a, b, lge[2], lge[1], lge[0]);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic gap(input logic s);
        in_valid = 1'b0; start = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    // A sample offered together with start must not be accepted.
    task automatic beginWindow();
        start = 1'b1; in_valid = 1'b1; A = 4'd1; B = 4'd2; {AlB, AgB, AeB} = 3'b100;
        modelClear();
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        chk("busyAfterStart", busy, 1);
        chk("ltAfterStart", lt_cnt, 0);
    endtask

    // Scoreboard: every done pulse pops and compares one window result.
    always @(negedge clk) begin
        if (done) begin
            doneSeen++;
            checks++;
            assert (expQ.size() > 0) else begin
                errors++;
                $error("FAIL doneUnexpected got=1 want=0");
            end
            if (expQ.size() > 0) begin
                monR = expQ.pop_front();
                chk("sbLt", lt_cnt, monR.lt);
                chk("sbGt", gt_cnt, monR.gt);
                chk("sbEq", eq_cnt, monR.eq);
                chk("sbMaxDiff", max_diff, monR.md);
                chk("sbErr", err, monR.er);
                chk("sbBusyAtDone", busy, 0);
            end
        end
    end

    logic [3:0] wa[5], wb[5], fa[5], fb[5], na[5], nb[5];
    logic [2:0] wf[5], ff[5], nf[5];
    int doneBefore;

    initial begin
        wa = '{4'd2, 4'd10, 4'd2, 4'd14, 4'd3};
        wb = '{4'd9, 4'd9,  4'd2, 4'd8,  4'd9};
        wf = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100};
        na = '{4'd1, 4'd9, 4'd6, 4'd6, 4'd12};
        nb = '{4'd4, 4'd5, 4'd6, 4'd6, 4'd11};
        nf = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b010};
        fa = '{4'd4, 4'd3, 4'd5, 4'd9, 4'd2};
        fb = '{4'd4, 4'd8, 4'd5, 4'd2, 4'd3};
        ff = '{3'b010, 3'b000, 3'b001, 3'b010, 3'b100};
        modelClear();

        rst = 1'b1; start = 1'b0; startSat = 1'b0; in_valid = 1'b0;
        A = 4'd0; B = 4'd0; AlB = 1'b0; AgB = 1'b0; AeB = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstBusy", busy, 0);
        chk("rstDone", done, 0);
        chk("rstLt", lt_cnt, 0);
        chk("rstGt", gt_cnt, 0);
        chk("rstEq", eq_cnt, 0);
        chk("rstMaxDiff", max_diff, 0);
        chk("rstErr", err, 0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) sample(4'd3, 4'd1, 3'b010, 1'b0);
        chk("idleGt", gt_cnt, 0);
        chk("idleBusy", busy, 0);

        // Back-to-back window.
        beginWindow();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("w1NoEarlyDone", done, 0);
            sample(wa[i], wb[i], wf[i], 1'b1);
        end
        chk("w1Done", done, 1);
        repeat (3) @(negedge clk);
        chk("w1HoldLt", lt_cnt, 2);
        chk("w1HoldGt", gt_cnt, 2);
        chk("w1HoldEq", eq_cnt, 1);
        chk("w1HoldMax", max_diff, 7);
        chk("w1HoldDone", done, 0);
        chk("w1Count", doneSeen, 1);

        // Gapped window with a start pulse mid-RUN.
        beginWindow();
        for (int i = 0; i < 5; i++) begin
            gap(i == 2);
            if (i == 4) begin
                chk("w2BusyBefore", busy, 1);
                chk("w2NoEarlyDone", done, 0);
            end
            sample(wa[i], wb[i], wf[i], 1'b1);
        end
        chk("w2Done", done, 1);
        @(negedge clk);

        // Saturation on the 2-bit instance; main instance is idle and must ignore these.
        startSat = 1'b1;
        @(negedge clk);
        startSat = 1'b0;
        for (int i = 0; i < SAT_WIN; i++) begin
            if (i == 5) chk("satEqEarly", eqSat, 3);
            sample(4'd5, 4'd5, 3'b001, 1'b0);
        end
        chk("satDone", doneSat, 1);
        chk("satEq", eqSat, 3);
        chk("satLt", ltSat, 0);
        chk("satGt", gtSat, 0);
        chk("satMax", maxSat, 0);
        chk("mainIgnoredEq", eq_cnt, 1);

        // Reset in the middle of a window.
        beginWindow();
        for (int i = 0; i < 3; i++) sample(wa[i], wb[i], wf[i], 1'b1);
        doneBefore = doneSeen;
        rst = 1'b1;
        #1;
        chk("midRstLt", lt_cnt, 0);
        chk("midRstGt", gt_cnt, 0);
        chk("midRstMax", max_diff, 0);
        chk("midRstBusy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        modelClear();
        repeat (3) @(negedge clk);
        chk("midRstNoDone", doneSeen, doneBefore);

        // Fresh window after the reset.
        beginWindow();
        for (int i = 0; i < 5; i++) sample(na[i], nb[i], nf[i], 1'b1);
        chk("w3Done", done, 1);
        @(negedge clk);

        // Anomalous flags: inconsistent gt, zero-hot.
        beginWindow();
        for (int i = 0; i < 5; i++) begin
            sample(fa[i], fb[i], ff[i], 1'b1);
`ifdef CMP_TALLY_ERRCHK_EN
            if (i == 0) begin
                chk("errSet", err, 1);
                chk("errGtUnchanged", gt_cnt, 0);
            end
`else
            if (i == 1) chk("zeroHotNoCount", lt_cnt + gt_cnt + eq_cnt, 1);
`endif
        end
        chk("w4Done", done, 1);
        @(negedge clk);

        // Next start clears err; run a full window.
        beginWindow();
        chk("errCleared", err, 0);
        for (int i = 0; i < 5; i++) sample(na[i], nb[i], nf[i], 1'b1);
        chk("w5Done", done, 1);
        repeat (2) @(negedge clk);

        chk("totalDone", doneSeen, 5);
        chk("queueEmpty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
